// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle processor.
// Moore controls decoded from the state register; fetch strobes qualified by mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXECI  = 4'd10,
    S_ALUIWB = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (opcode < 6'd5):
            state_d = S_EXEC;
          (opcode >= 6'd5) && (opcode < 6'd10):
            state_d = S_EXECI;
          (opcode == 6'd10) || (opcode == 6'd11):
            state_d = S_MEMADR;
          (opcode == 6'd12):
            state_d = S_BRANCH;
          (opcode == 6'd13):
            state_d = S_JUMP;
          (opcode > 6'd13): begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == 6'd10) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset masks every control so nothing fires while the FSM is held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_EXECI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        S_ALUIWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed table, corner sequences
// and random instruction streams against a path-level model.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic       illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic       chk;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  vec_t vt[$];
  vec_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic ill_m;

  function automatic logic [15:0] cw(
    input logic pcw, pcc, iord, mrd, mwr, m2r, irw, rw, rd, asa,
    input logic [1:0] asb, pcs, aop);
    return {pcw, pcc, iord, mrd, mwr, m2r, irw, rw, rd, asa, asb, pcs, aop};
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st,
                                           input logic mr);
    case (st)
      4'd0:  return cw(mr,0,0,1,0,0,mr,0,0,0, 2'b01, 2'b00, 2'b00);
      4'd1:  return cw(0,0,0,0,0,0,0,0,0,0,   2'b11, 2'b00, 2'b00);
      4'd2:  return cw(0,0,0,0,0,0,0,0,0,1,   2'b10, 2'b00, 2'b00);
      4'd3:  return cw(0,0,1,1,0,0,0,0,0,0,   2'b00, 2'b00, 2'b00);
      4'd4:  return cw(0,0,0,0,0,1,0,1,0,0,   2'b00, 2'b00, 2'b00);
      4'd5:  return cw(0,0,1,0,1,0,0,0,0,0,   2'b00, 2'b00, 2'b00);
      4'd6:  return cw(0,0,0,0,0,0,0,0,0,1,   2'b00, 2'b00, 2'b10);
      4'd7:  return cw(0,0,0,0,0,0,0,1,1,0,   2'b00, 2'b00, 2'b00);
      4'd8:  return cw(0,1,0,0,0,0,0,0,0,1,   2'b00, 2'b01, 2'b01);
      4'd9:  return cw(1,0,0,0,0,0,0,0,0,0,   2'b00, 2'b10, 2'b00);
      4'd10: return cw(0,0,0,0,0,0,0,0,0,1,   2'b10, 2'b00, 2'b10);
      4'd11: return cw(0,0,0,0,0,0,0,1,0,0,   2'b00, 2'b00, 2'b00);
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] ctrl_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp};
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle at the falling edge, advance.
  task automatic step(input vec_t v);
    reset     = v.rst;
    opcode    = v.op;
    mem_ready = v.mr;
    @(negedge clk);
    if (v.chk) begin
      cmp("state", {12'h0, state}, {12'h0, v.st});
      cmp("illegal_op", {15'h0, illegal_op}, {15'h0, v.ill});
    end
    cmp("ctrl", ctrl_now(), v.rst ? 16'h0 : exp_ctrl(v.st, v.mr));
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [5:0] op,
                              input logic mr, input logic c,
                              input logic [3:0] st, input logic ill);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.chk = c; v.st = st; v.ill = ill;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Model: expand one instruction into its per-cycle state path.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) q.push_back(mk(0, 6'($urandom), 0, 1, 0, ill_m));
    q.push_back(mk(0, 6'($urandom), 1, 1, 0, ill_m));
    q.push_back(mk(0, op, rb(), 1, 1, ill_m));
    if (op < 5) begin
      q.push_back(mk(0, 6'($urandom), rb(), 1, 6, ill_m));
      q.push_back(mk(0, 6'($urandom), rb(), 1, 7, ill_m));
    end else if (op < 10) begin
      q.push_back(mk(0, 6'($urandom), rb(), 1, 10, ill_m));
      q.push_back(mk(0, 6'($urandom), rb(), 1, 11, ill_m));
    end else if (op == 10) begin
      q.push_back(mk(0, op, rb(), 1, 2, ill_m));
      for (int i = 0; i < mw; i++) q.push_back(mk(0, 6'($urandom), 0, 1, 3, ill_m));
      q.push_back(mk(0, 6'($urandom), 1, 1, 3, ill_m));
      q.push_back(mk(0, 6'($urandom), rb(), 1, 4, ill_m));
    end else if (op == 11) begin
      q.push_back(mk(0, op, rb(), 1, 2, ill_m));
      for (int i = 0; i < mw; i++) q.push_back(mk(0, 6'($urandom), 0, 1, 5, ill_m));
      q.push_back(mk(0, 6'($urandom), 1, 1, 5, ill_m));
    end else if (op == 12) begin
      q.push_back(mk(0, 6'($urandom), rb(), 1, 8, ill_m));
    end else if (op == 13) begin
      q.push_back(mk(0, 6'($urandom), rb(), 1, 9, ill_m));
    end else begin
      ill_m = 1'b1;
    end
  endtask

  initial begin
    int cyc, irw_n, m2r_n, fw_n, mw_n;
    logic left;
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    #1;

    // Directed table: reset, add, sw, beq, j, illegal then addi, reset.
    vt.push_back(mk(1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 6, 0));
    vt.push_back(mk(0, 0, 1, 1, 7, 0));
    vt.push_back(mk(0, 11, 1, 1, 0, 0));
    vt.push_back(mk(0, 11, 1, 1, 1, 0));
    vt.push_back(mk(0, 11, 1, 1, 2, 0));
    vt.push_back(mk(0, 11, 1, 1, 5, 0));
    vt.push_back(mk(0, 12, 1, 1, 0, 0));
    vt.push_back(mk(0, 12, 1, 1, 1, 0));
    vt.push_back(mk(0, 12, 1, 1, 8, 0));
    vt.push_back(mk(0, 13, 1, 1, 0, 0));
    vt.push_back(mk(0, 13, 1, 1, 1, 0));
    vt.push_back(mk(0, 13, 1, 1, 9, 0));
    vt.push_back(mk(0, 20, 1, 1, 0, 0));
    vt.push_back(mk(0, 20, 1, 1, 1, 0));
    vt.push_back(mk(0, 5, 1, 1, 0, 1));
    vt.push_back(mk(0, 5, 1, 1, 1, 1));
    vt.push_back(mk(0, 5, 1, 1, 10, 1));
    vt.push_back(mk(0, 5, 1, 1, 11, 1));
    vt.push_back(mk(1, 5, 1, 1, 0, 1));
    vt.push_back(mk(0, 5, 0, 1, 0, 0));
    foreach (vt[i]) step(vt[i]);

    // lw with 2 fetch and 3 memory wait cycles.
    step(mk(1, 0, 0, 1, 0, 0));
    cyc = 0; irw_n = 0; m2r_n = 0; fw_n = 0; mw_n = 0; left = 1'b0;
    while (cyc < 30) begin
      reset = 1'b0;
      opcode = 6'd10;
      mem_ready = 1'b1;
      if (state == 4'd0) begin
        mem_ready = (fw_n >= 2);
        fw_n++;
      end else if (state == 4'd3) begin
        mem_ready = (mw_n >= 3);
        mw_n++;
      end
      @(negedge clk);
      if (IRWrite) irw_n++;
      if (MemtoReg) m2r_n++;
      @(posedge clk);
      #1;
      cyc++;
      if (state != 4'd0) left = 1'b1;
      if (left && state == 4'd0) break;
    end
    cmp("lw_cycles", 16'(cyc), 16'd10);
    cmp("lw_irwrite_pulses", 16'(irw_n), 16'd1);
    cmp("lw_memtoreg_cycles", 16'(m2r_n), 16'd1);

    // Reset while waiting in MEMRD.
    step(mk(0, 10, 1, 1, 0, 0));
    step(mk(0, 10, 1, 1, 1, 0));
    step(mk(0, 10, 1, 1, 2, 0));
    step(mk(0, 10, 0, 1, 3, 0));
    step(mk(1, 10, 1, 1, 3, 0));
    step(mk(0, 10, 1, 1, 0, 0));
    step(mk(0, 10, 1, 1, 1, 0));
    step(mk(0, 10, 1, 1, 2, 0));
    step(mk(0, 10, 1, 1, 3, 0));
    step(mk(0, 10, 1, 1, 4, 0));

    // Random instruction streams against the path model.
    step(mk(1, 0, 0, 1, 0, 0));
    ill_m = 1'b0;
    for (int n = 0; n < 200; n++) begin
      int sel;
      logic [5:0] op;
      sel = int'($urandom_range(0, 15));
      op = (sel >= 14) ? 6'($urandom_range(14, 63)) : 6'(sel);
      add_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      while (q.size() > 0) step(q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
